// File: rtl/fpga_blocks_pkg.sv
// Shared constants for the small FPGA building blocks (gates, debouncers).
//
// Contents:
//   CLK_HZ                  system clock frequency in Hz
//   DEBOUNCE_MS             default debounce qualification time in ms
//   ms_to_cycles()          converts a millisecond figure into clk cycles
//   DEBOUNCE_CYCLES_DEFAULT default qualification length in clk cycles
package fpga_blocks_pkg;

  localparam int CLK_HZ      = 100_000_000;
  localparam int DEBOUNCE_MS = 10;

  // Divide first so the intermediate product stays inside 32 bits.
  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int DEBOUNCE_CYCLES_DEFAULT = ms_to_cycles(DEBOUNCE_MS);

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchronizer chain, persistence counter, accepted
// level flop and registered edge pulses.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset, clears every flop to 0
//   raw    raw input, asynchronous to clk, may bounce
//   level  debounced level (registered)
//   rise   one-cycle pulse in the cycle level goes 0->1
//   fall   one-cycle pulse in the cycle level goes 1->0
//
// Channel state is the pair {level, cnt}:
//   level=0,cnt=0 stable low    level=0,cnt>0 waiting to go high
//   level=1,cnt=0 stable high   level=1,cnt>0 waiting to go low
// A new synchronized level must differ from the accepted level on
// DEBOUNCE_CYCLES consecutive edges before it is taken; any edge where it
// agrees again sends cnt back to 0, so shorter bounces are dropped entirely.
module debounce_ch
  import fpga_blocks_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  // Last count value before a transition is accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("debounce_ch: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
      $error("debounce_ch: DEBOUNCE_CYCLES must be >= 1");
    end
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
      $error("debounce_ch: CNT_W too small, need 2**CNT_W > DEBOUNCE_CYCLES");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt;

  // Plain flop chain, nothing between stages, so metastability resolution
  // time is not eaten by logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        // cnt never exceeds CNT_MAX, so != is the same as < here.
        cnt <= cnt + 1'b1;
      end else begin
        // Pulses are set from the same condition that flips level, so they
        // line up with the output change.
        level <= s;
        cnt   <= '0;
        rise  <= s;
        fall  <= ~s;
      end
    end
  end

endmodule

// File: rtl/debounce2.sv
// Two-channel input conditioner feeding the 2-input gate blocks.
// Turns raw bouncing lines a_raw/b_raw into clean synchronous levels a/b
// plus one-cycle rise/fall pulses per channel. The channels are
// independent copies of debounce_ch; this level only wires ports.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   a_raw, b_raw   raw inputs, asynchronous to clk
//   a, b           debounced levels
//   a_rise, a_fall one-cycle edge pulses for a
//   b_rise, b_fall one-cycle edge pulses for b
module debounce2
  import fpga_blocks_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch_a (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (a_raw),
    .level(a),
    .rise (a_rise),
    .fall (a_fall)
  );

  debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch_b (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (b_raw),
    .level(b),
    .rise (b_rise),
    .fall (b_fall)
  );

endmodule

// File: tb/tb_debounce2.sv
// Bench for debounce2 with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CNT_W=3.
// Output vectors are packed as {a, b, a_rise, a_fall, b_rise, b_fall}.
// The driver issues one input vector per clock at the falling edge and
// pushes the expected output vector for the following rising edge; the
// monitor pops one entry per rising edge and compares.
module tb_debounce2;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int CW   = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic a_raw, b_raw;
  logic a, b, a_rise, a_fall, b_rise, b_fall;
  logic [5:0] dut_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] exp_q[$];
  string      name_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  debounce2 #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a_raw (a_raw),
    .b_raw (b_raw),
    .a     (a),
    .b     (b),
    .a_rise(a_rise),
    .a_fall(a_fall),
    .b_rise(b_rise),
    .b_fall(b_fall)
  );

  assign dut_out = {a, b, a_rise, a_fall, b_rise, b_fall};

  // ---------------- driver tasks ----------------
  task automatic step(input logic ar, input logic br, input logic rn,
                      input logic [5:0] exp_v, input string nm);
    @(negedge clk);
    a_raw = ar;
    b_raw = br;
    rst_n = rn;
    exp_q.push_back(exp_v);
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  // Immediate check of the outputs as they stand (used for async reset).
  task automatic check_now(input string nm, input logic [5:0] exp_v);
    n_tests++;
    if (dut_out !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got {a,b,ar,af,br,bf}=%b expected %b", nm, dut_out, exp_v);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [5:0] prev_out = '0;
  always @(posedge clk) begin
    logic [5:0] e;
    string      nm;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_tests++;
      if (dut_out !== e) begin
        n_fail++;
        $display("FAIL %s: got {a,b,ar,af,br,bf}=%b expected %b", nm, dut_out, e);
      end
      n_tests++;
      if ((prev_out[3:0] & dut_out[3:0]) != 4'b0000) begin
        n_fail++;
        $display("FAIL %s_pulse_b2b: pulses prev=%b now=%b expected no repeat",
                 nm, prev_out[3:0], dut_out[3:0]);
      end
    end
    prev_out = dut_out;
  end

  // ---------------- reference model for the random phase ----------------
  // A level is accepted when the synchronized input (raw delayed SYNC
  // edges) has differed from the held level on each of the last DEB edges.
  logic [7:0] ha, hb;
  logic       st_a, st_b;

  function automatic logic qualifies(input logic [7:0] h, input logic st);
    logic ok;
    ok = 1'b1;
    for (int j = 0; j < DEB; j++) begin
      if (h[SYNC + j] == st) ok = 1'b0;
    end
    return ok;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] ev;
    logic       ar, br, fa, fb;
    int         hold_a, hold_b;
    logic [11:0] bounce;

    // Test 1a: reset from time 0 with raw inputs high.
    rst_n = 1'b0;
    a_raw = 1'b1;
    b_raw = 1'b1;
    #2 check_now("reset_init", 6'b000000);
    @(negedge clk);
    check_now("reset_hold0", 6'b000000);
    #2 a_raw = 1'b0; b_raw = 1'b0;
    #1 check_now("reset_toggle", 6'b000000);
    #1 a_raw = 1'b1; b_raw = 1'b1;
    step(1'b1, 1'b1, 1'b0, 6'b000000, "reset_hold1");
    step(1'b1, 1'b1, 1'b0, 6'b000000, "reset_hold2");
    step(1'b0, 1'b0, 1'b1, 6'b000000, "release_idle");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 6'b000000, "idle");

    // Test 3: bounce 3 high, 1 low, 3 high, then low: must be rejected.
    bounce = 12'b111011100000;
    for (int i = 11; i >= 0; i--)
      step(bounce[i], 1'b0, 1'b1, 6'b000000, "bounce_reject");

    // Test 2: clean step on A; rise on the 6th edge, b untouched.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 6'b000000, "step_wait");
    step(1'b1, 1'b0, 1'b1, 6'b101000, "step_rise");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 6'b100000, "step_hold");

    // Test 4: a falls and b rises in the same cycle.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 6'b100000, "fr_wait");
    step(1'b0, 1'b1, 1'b1, 6'b010110, "fr_pulses");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 6'b010000, "fr_hold");

    // Test 1b: reset asserted mid-cycle while b=1, outputs clear at once.
    @(negedge clk);
    a_raw = 1'b1;
    b_raw = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_now("async_reset", 6'b000000);
    step(1'b1, 1'b1, 1'b0, 6'b000000, "reset_mid_hold1");
    step(1'b1, 1'b1, 1'b0, 6'b000000, "reset_mid_hold2");
    step(1'b0, 1'b0, 1'b0, 6'b000000, "reset_mid_hold3");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 6'b000000, "release_idle2");

    // Test 5: reset in the middle of a pending rise.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 6'b000000, "midwait_pend");
    step(1'b1, 1'b0, 1'b0, 6'b000000, "midwait_rst1");
    step(1'b1, 1'b0, 1'b0, 6'b000000, "midwait_rst2");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 6'b000000, "midwait_requal");
    step(1'b1, 1'b0, 1'b1, 6'b101000, "midwait_rise");
    step(1'b1, 1'b0, 1'b1, 6'b100000, "midwait_hold");

    // Test 6: random bursts against the reference model, from a fresh reset.
    step(1'b0, 1'b0, 1'b0, 6'b000000, "rand_reset");
    ha = '0; hb = '0; st_a = 1'b0; st_b = 1'b0;
    ar = 1'b0; br = 1'b0; hold_a = 0; hold_b = 0;
    for (int c = 0; c < 10000; c++) begin
      if (hold_a == 0) begin ar = 1'($urandom_range(0, 1)); hold_a = $urandom_range(1, 7); end
      if (hold_b == 0) begin br = 1'($urandom_range(0, 1)); hold_b = $urandom_range(1, 7); end
      hold_a--;
      hold_b--;
      ha = {ha[6:0], ar};
      hb = {hb[6:0], br};
      fa = qualifies(ha, st_a);
      fb = qualifies(hb, st_b);
      if (fa) st_a = ~st_a;
      if (fb) st_b = ~st_b;
      ev = {st_a, st_b, fa & st_a, fa & ~st_a, fb & st_b, fb & ~st_b};
      step(ar, br, 1'b1, ev, "random");
    end

    // Let the monitor consume the last entry, then confirm nothing is left.
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
